// File: rtl/controle_boot.sv
// Boot sequencer for the iZero CPU: BIOS fetch, HD-to-instruction-RAM copy, then user restart at PC 0.
// Optional BOOT_CHECKSUM_EN adds a checksum output summing every word written to instruction RAM.
module controle_boot #(
    parameter int BIOS_SIZE  = 54,
    parameter int HD_ADDR_W  = 16,
    parameter int MEM_ADDR_W = 26
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [MEM_ADDR_W-1:0] pc,
    input  logic [31:0]           instr_bios,
    input  logic [31:0]           instr_mem,
    input  logic [HD_ADDR_W-1:0]  tam_prog,
    input  logic                  hd_ack,
    input  logic [31:0]           hd_dado,
    output logic [31:0]           instrucao,
    output logic                  cpu_stall,
    output logic                  pc_reset,
    output logic                  hd_req,
    output logic [HD_ADDR_W-1:0]  hd_addr,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_dado,
    output logic                  modo_user
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    typedef enum logic [2:0] {
        S_BIOS, S_LE, S_GRAVA, S_LIBERA, S_USER, S_PARADO
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [HD_ADDR_W-1:0]  r_count;
    logic [HD_ADDR_W-1:0]  r_len;
    logic [HD_ADDR_W-1:0]  w_count_inc;
    logic [31:0]           r_mem_dado;
    logic                  w_halt;

    assign w_count_inc = r_count + HD_ADDR_W'(1);
    assign hd_addr     = r_count;
    assign mem_addr    = {{(MEM_ADDR_W-HD_ADDR_W){1'b0}}, r_count};
    assign mem_dado    = r_mem_dado;

    // Outputs decode the state register only, so cpu_stall rises the cycle after a halt is fetched.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        w_next    = r_state;
        instrucao = '0;
        cpu_stall = 1'b0;
        pc_reset  = 1'b0;
        hd_req    = 1'b0;
        mem_we    = 1'b0;
        modo_user = 1'b0;
        case (r_state)
            S_BIOS: begin
                instrucao = (pc < MEM_ADDR_W'(BIOS_SIZE)) ? instr_bios : '0;
            end
            S_LE: begin
                hd_req    = 1'b1;
                cpu_stall = 1'b1;
                if (hd_ack) w_next = S_GRAVA;
            end
            S_GRAVA: begin
                mem_we    = 1'b1;
                cpu_stall = 1'b1;
                w_next    = (w_count_inc == r_len) ? S_LIBERA : S_LE;
            end
            S_LIBERA: begin
                pc_reset  = 1'b1;
                cpu_stall = 1'b1;
                w_next    = S_USER;
            end
            S_USER: begin
                modo_user = 1'b1;
                instrucao = instr_mem;
            end
            S_PARADO: begin
                cpu_stall = 1'b1;
                modo_user = 1'b1;
            end
            default: w_next = S_BIOS;
        endcase

        w_halt = (instrucao[31:26] == 6'b111111) && !cpu_stall;
        if (w_halt) begin
            if (r_state == S_BIOS)
                w_next = (tam_prog == '0) ? S_LIBERA : S_LE;
            else if (r_state == S_USER)
                w_next = S_PARADO;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_state    <= S_BIOS;
            r_count    <= '0;
            r_len      <= '0;
            r_mem_dado <= '0;
        end else begin
            r_state <= w_next;
            if (w_halt && r_state == S_BIOS) begin
                r_len   <= tam_prog;
                r_count <= '0;
            end
            if (r_state == S_LE && hd_ack)
                r_mem_dado <= hd_dado;
            if (r_state == S_GRAVA)
                r_count <= w_count_inc;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_checksum <= '0;
        else if (w_halt && r_state == S_BIOS)
            r_checksum <= '0;
        else if (r_state == S_GRAVA)
            r_checksum <= r_checksum + r_mem_dado;
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_controle_boot.sv
// Directed self-checking bench for controle_boot: BIOS fetch, copy, empty program, HD stall,
// mid-copy reset and user halt.
module tb_controle_boot;

    logic        clock;
    logic        resetn;
    logic [25:0] pc;
    logic [31:0] instr_bios;
    logic [31:0] instr_mem;
    logic [15:0] tam_prog;
    logic        hd_ack;
    logic [31:0] hd_dado;
    logic [31:0] instrucao;
    logic        cpu_stall;
    logic        pc_reset;
    logic        hd_req;
    logic [15:0] hd_addr;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic [31:0] mem_dado;
    logic        modo_user;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_pcr    = 0;

    controle_boot dut (
        .clock      (clock),
        .resetn     (resetn),
        .pc         (pc),
        .instr_bios (instr_bios),
        .instr_mem  (instr_mem),
        .tam_prog   (tam_prog),
        .hd_ack     (hd_ack),
        .hd_dado    (hd_dado),
        .instrucao  (instrucao),
        .cpu_stall  (cpu_stall),
        .pc_reset   (pc_reset),
        .hd_req     (hd_req),
        .hd_addr    (hd_addr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_dado   (mem_dado),
        .modo_user  (modo_user)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled on the falling edge, away from state updates.
    always @(negedge clock) begin
        if (mem_we)   n_we  = n_we + 1;
        if (pc_reset) n_pcr = n_pcr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        hd_ack     = 1'b0;
        hd_dado    = '0;
        tam_prog   = '0;
        pc         = '0;
        instr_bios = 32'h0400_0000;
        instr_mem  = '0;
        @(posedge clock);
        #1;
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_pcr",   {31'b0, pc_reset},  32'd0);
        check("rst_req",   {31'b0, hd_req},    32'd0);
        check("rst_we",    {31'b0, mem_we},    32'd0);
        check("rst_user",  {31'b0, modo_user}, 32'd0);
        resetn = 1'b1;
        #1;
    endtask

    // Drives a halt word from the BIOS and steps into the next state.
    task automatic bios_halt(input logic [15:0] len);
        pc         = 26'd5;
        instr_bios = 32'hFC00_0000;
        tam_prog   = len;
        #1;
        check("halt_pre_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        tam_prog   = 16'd7;
        instr_bios = 32'h0400_0000;
        #1;
    endtask

    logic [31:0] data_tbl [3] = '{32'd11, 32'd22, 32'd33};

    initial begin
        int we0;
        int pcr0;

        // Test 1: BIOS fetch window and the NOP region past the ROM.
        do_reset();
        for (int i = 0; i < 54; i++) begin
            pc         = 26'(i);
            instr_bios = 32'h0800_0000 | 32'(i);
            #1;
            if (instrucao !== (32'h0800_0000 | 32'(i))) check("bios_fetch", instrucao, 32'h0800_0000 | 32'(i));
            else n_checks = n_checks + 1;
        end
        check("bios_stall", {31'b0, cpu_stall}, 32'd0);
        check("bios_user",  {31'b0, modo_user}, 32'd0);
        pc = 26'd54; #1;
        check("bios_pc54", instrucao, 32'd0);
        pc = 26'd60; instr_bios = 32'hFC00_0000; #1;
        check("bios_pc60", instrucao, 32'd0);
        tick();
        check("bios_pc60_nohalt", {31'b0, cpu_stall}, 32'd0);

        // Test 2: three-word copy, ack two cycles after each request.
        do_reset();
        we0  = n_we;
        pcr0 = n_pcr;
        bios_halt(16'd3);
        check("cp_stall", {31'b0, cpu_stall}, 32'd1);
        check("cp_instr", instrucao, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("cp_req",  {31'b0, hd_req}, 32'd1);
            check("cp_addr", {16'b0, hd_addr}, 32'(k));
            tick();
            tick();
            check("cp_req_hold", {31'b0, hd_req}, 32'd1);
            check("cp_we_idle",  {31'b0, mem_we}, 32'd0);
            hd_ack  = 1'b1;
            hd_dado = data_tbl[k];
            tick();
            hd_ack  = 1'b0;
            hd_dado = 32'hDEAD_BEEF;
            #1;
            check("cp_we",      {31'b0, mem_we}, 32'd1);
            check("cp_maddr",   {6'b0, mem_addr}, 32'(k));
            check("cp_mdado",   mem_dado, data_tbl[k]);
            check("cp_req_low", {31'b0, hd_req}, 32'd0);
            tick();
        end
        check("cp_pcr",        {31'b0, pc_reset},  32'd1);
        check("cp_pcr_stall",  {31'b0, cpu_stall}, 32'd1);
        check("cp_pcr_user",   {31'b0, modo_user}, 32'd0);
        instr_mem = 32'h2000_0001;
        tick();
        check("cp_usr_pcr",   {31'b0, pc_reset},  32'd0);
        check("cp_usr_mode",  {31'b0, modo_user}, 32'd1);
        check("cp_usr_stall", {31'b0, cpu_stall}, 32'd0);
        check("cp_usr_instr", instrucao, 32'h2000_0001);
`ifdef BOOT_CHECKSUM_EN
        check("cp_checksum", checksum, 32'd66);
`endif
        tick();
        tick();
        check("cp_we_count",  32'(n_we - we0),   32'd3);
        check("cp_pcr_count", 32'(n_pcr - pcr0), 32'd1);

        // Test 3: empty program goes straight to restart.
        do_reset();
        pcr0 = n_pcr;
        bios_halt(16'd0);
        check("z_req",   {31'b0, hd_req},    32'd0);
        check("z_pcr",   {31'b0, pc_reset},  32'd1);
        check("z_stall", {31'b0, cpu_stall}, 32'd1);
        tick();
        check("z_user",  {31'b0, modo_user}, 32'd1);
        check("z_pcr0",  {31'b0, pc_reset},  32'd0);
        tick();
        check("z_pcr_count", 32'(n_pcr - pcr0), 32'd1);

        // Test 4: stray ack in BIOS is ignored; HD stall holds the request.
        do_reset();
        hd_ack  = 1'b1;
        hd_dado = 32'hCAFE_0001;
        tick();
        hd_ack = 1'b0;
        #1;
        check("stray_mdado", mem_dado, 32'd0);
        check("stray_stall", {31'b0, cpu_stall}, 32'd0);
        check("stray_req",   {31'b0, hd_req}, 32'd0);
        bios_halt(16'd2);
        for (int c = 0; c < 20; c++) begin
            check("hold_req",   {31'b0, hd_req},    32'd1);
            check("hold_addr",  {16'b0, hd_addr},   32'd0);
            check("hold_we",    {31'b0, mem_we},    32'd0);
            check("hold_stall", {31'b0, cpu_stall}, 32'd1);
            tick();
        end

        // Test 5: reset during the second of four words.
        do_reset();
        bios_halt(16'd4);
        tick();
        tick();
        hd_ack  = 1'b1;
        hd_dado = 32'h0000_00AA;
        tick();
        hd_ack = 1'b0;
        #1;
        check("ab_w0", {31'b0, mem_we}, 32'd1);
        tick();
        check("ab_addr1", {16'b0, hd_addr}, 32'd1);
        tick();
        resetn = 1'b0;
        #1;
        check("ab_stall", {31'b0, cpu_stall}, 32'd0);
        check("ab_req",   {31'b0, hd_req},    32'd0);
        check("ab_we",    {31'b0, mem_we},    32'd0);
        check("ab_pcr",   {31'b0, pc_reset},  32'd0);
        check("ab_user",  {31'b0, modo_user}, 32'd0);
        check("ab_haddr", {16'b0, hd_addr},   32'd0);
        check("ab_maddr", {6'b0, mem_addr},   32'd0);
        check("ab_mdado", mem_dado,           32'd0);
        tick();
        resetn     = 1'b1;
        pc         = 26'd2;
        instr_bios = 32'h0400_0002;
        #1;
        check("ab_bios", instrucao, 32'h0400_0002);
        tick();
        check("ab_bios_stall", {31'b0, cpu_stall}, 32'd0);

        // Test 6: halt in user mode parks the CPU until reset.
        do_reset();
        bios_halt(16'd0);
        tick();
        instr_mem = 32'hFC00_0000;
        #1;
        check("ph_pre_instr", instrucao, 32'hFC00_0000);
        check("ph_pre_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        check("ph_stall", {31'b0, cpu_stall}, 32'd1);
        check("ph_instr", instrucao, 32'd0);
        for (int c = 0; c < 10; c++) begin
            instr_mem = 32'h0000_1234;
            hd_ack    = c[0];
            tick();
            check("ph_hold_stall", {31'b0, cpu_stall}, 32'd1);
            check("ph_hold_we",    {31'b0, mem_we},    32'd0);
            check("ph_hold_req",   {31'b0, hd_req},    32'd0);
        end
        hd_ack = 1'b0;
        do_reset();
        check("ph_exit_stall", {31'b0, cpu_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
